// File: rtl/vga_timing_rx.sv
// VGA receive front-end: measures HS/VS geometry, locks to the nominal timing and
// recovers active-pixel coordinates and data two clocks after the input samples.
module vga_timing_rx #(
  parameter int H_SYNC      = 136,
  parameter int H_BACK      = 160,
  parameter int H_DISP      = 1024,
  parameter int H_TOTAL     = 1344,
  parameter int V_SYNC      = 6,
  parameter int V_BACK      = 29,
  parameter int V_DISP      = 768,
  parameter int V_TOTAL     = 806,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [15:0] vga_rgb,
  output logic        pixel_valid,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [15:0] pixel_data,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [10:0] meas_h_total,
  output logic [10:0] meas_v_total
);

  localparam logic [1:0]  ST_SEARCH = 2'd0;
  localparam logic [1:0]  ST_VERIFY = 2'd1;
  localparam logic [1:0]  ST_LOCKED = 2'd2;
  localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
  localparam logic [11:0] H_SYNC_W  = 12'(H_SYNC);
  localparam logic [11:0] V_TOTAL_W = 12'(V_TOTAL);
  localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
  localparam logic [10:0] H_ACT_LO  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_ACT_HI  = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] V_ACT_LO  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_HI  = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] CNT_MAX   = 11'd2047;
  localparam logic [3:0]  LOCK_W    = 4'(LOCK_FRAMES);

  logic        s1_hs_r, s1_vs_r;
  logic [15:0] s1_rgb_r;
  logic [10:0] h_cnt_r, v_cnt_r, v_sync_meas_r;
  logic        line_err_r;
  logic [1:0]  state_r, state_nxt_s;
  logic [3:0]  good_cnt_r, good_nxt_s;
  logic        terr_nxt_s;

  // Edge detection compares the live input against the s1 copy; the 12-bit +1
  // makes a saturated counter never match a geometry constant.
  logic        hs_fall_s, hs_rise_s, vs_fall_s, vs_rise_s;
  logic [11:0] h_inc_s, v_inc_s;
  logic        hs_fall_bad_s, hs_rise_bad_s, frame_ok_s, wdog_s;
  logic [10:0] pix_x_s, pix_y_s;
  logic        win_s, pv_s;

  assign hs_fall_s     = s1_hs_r & ~vga_hs;
  assign hs_rise_s     = ~s1_hs_r & vga_hs;
  assign vs_fall_s     = s1_vs_r & ~vga_vs;
  assign vs_rise_s     = ~s1_vs_r & vga_vs;
  assign h_inc_s       = {1'b0, h_cnt_r} + 12'd1;
  assign v_inc_s       = {1'b0, v_cnt_r} + 12'd1;
  assign hs_fall_bad_s = hs_fall_s & (h_inc_s != H_TOTAL_W);
  assign hs_rise_bad_s = hs_rise_s & (h_inc_s != H_SYNC_W);
  assign frame_ok_s    = ~line_err_r & ~hs_fall_bad_s & (v_inc_s == V_TOTAL_W) &
                         (v_sync_meas_r == V_SYNC_W);
  assign wdog_s        = (h_cnt_r == CNT_MAX);

  // Lock FSM next state; vs_fall wins over the watchdog so a frame edge that ends
  // a long HS outage can already start verification.
  always_comb begin
    state_nxt_s = state_r;
    good_nxt_s  = good_cnt_r;
    terr_nxt_s  = 1'b0;
    if (vs_fall_s) begin
      case (state_r)
        ST_SEARCH: begin
          state_nxt_s = ST_VERIFY;
          good_nxt_s  = 4'd0;
        end
        ST_VERIFY: begin
          if (frame_ok_s) begin
            good_nxt_s = good_cnt_r + 4'd1;
            if ((good_cnt_r + 4'd1) == LOCK_W) begin
              state_nxt_s = ST_LOCKED;
            end else begin
              state_nxt_s = ST_VERIFY;
            end
          end else begin
            good_nxt_s = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (!frame_ok_s) begin
            state_nxt_s = ST_SEARCH;
            terr_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        default: begin
          state_nxt_s = ST_SEARCH;
          good_nxt_s  = 4'd0;
        end
      endcase
    end else if (wdog_s) begin
      state_nxt_s = ST_SEARCH;
      terr_nxt_s  = (state_r == ST_LOCKED);
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Input stage, line/frame counters, measurements and lock state.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_hs_r       <= 1'b1;
      s1_vs_r       <= 1'b1;
      s1_rgb_r      <= 16'd0;
      h_cnt_r       <= 11'd0;
      v_cnt_r       <= 11'd0;
      v_sync_meas_r <= 11'd0;
      meas_h_total  <= 11'd0;
      meas_v_total  <= 11'd0;
      line_err_r    <= 1'b0;
      state_r       <= ST_SEARCH;
      good_cnt_r    <= 4'd0;
      timing_err    <= 1'b0;
      locked        <= 1'b0;
    end else begin
      s1_hs_r  <= vga_hs;
      s1_vs_r  <= vga_vs;
      s1_rgb_r <= vga_rgb;
      if (hs_fall_s) begin
        h_cnt_r      <= 11'd0;
        meas_h_total <= h_inc_s[10:0];
      end else if (h_cnt_r != CNT_MAX) begin
        h_cnt_r <= h_cnt_r + 11'd1;
      end
      if (vs_fall_s) begin
        v_cnt_r      <= 11'd0;
        meas_v_total <= v_inc_s[10:0];
      end else if (hs_fall_s && (v_cnt_r != CNT_MAX)) begin
        v_cnt_r <= v_cnt_r + 11'd1;
      end
      if (vs_rise_s) begin
        v_sync_meas_r <= v_inc_s[10:0];
      end
      if (vs_fall_s) begin
        line_err_r <= 1'b0;
      end else if (hs_fall_bad_s || hs_rise_bad_s) begin
        line_err_r <= 1'b1;
      end
      state_r    <= state_nxt_s;
      good_cnt_r <= good_nxt_s;
      timing_err <= terr_nxt_s;
      locked     <= (state_nxt_s == ST_LOCKED);
    end
  end

  assign pix_x_s = h_cnt_r - H_ACT_LO;
  assign pix_y_s = v_cnt_r - V_ACT_LO;
  assign win_s   = (h_cnt_r >= H_ACT_LO) && (h_cnt_r < H_ACT_HI) &&
                   (v_cnt_r >= V_ACT_LO) && (v_cnt_r < V_ACT_HI);
  assign pv_s    = locked & win_s;

  // Output stage: coordinates and data are forced to zero outside valid pixels.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pixel_valid <= 1'b0;
      pixel_xpos  <= 11'd0;
      pixel_ypos  <= 11'd0;
      pixel_data  <= 16'd0;
      frame_start <= 1'b0;
    end else begin
      pixel_valid <= pv_s;
      frame_start <= pv_s & (pix_x_s == 11'd0) & (pix_y_s == 11'd0);
      if (pv_s) begin
        pixel_xpos <= pix_x_s;
        pixel_ypos <= pix_y_s;
        pixel_data <= s1_rgb_r;
      end else begin
        pixel_xpos <= 11'd0;
        pixel_ypos <= 11'd0;
        pixel_data <= 16'd0;
      end
    end
  end

endmodule
